// File: rtl/wash_seq_ctrl.sv
// wash_seq_ctrl: washing-machine drum sequencer.
// Each wash cycle runs CW -> P1 (pause) -> CCW -> P2 (pause), repeated
// 'cycles' times. hold freezes the sequence, abort ends it early, and done
// pulses once when a run completes normally.
// Optional feature macro: WASH_LID_INTERLOCK_EN adds a lid_open input. An
// open lid acts as hold while running and blocks start while idle.
// Control semantics: start/cycles are sampled only in IDLE. hold is a level.
// abort is sampled on every edge while busy. There is no valid/ready
// handshake. The phase output exposes the FSM state directly.
module wash_seq_ctrl #(
    parameter int TW      = 8,
    parameter int CW_T    = 20,
    parameter int CCW_T   = 20,
    parameter int PAUSE_T = 10,
    parameter int NW      = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [NW-1:0] cycles,
    input  logic          hold,
    input  logic          abort,
`ifdef WASH_LID_INTERLOCK_EN
    input  logic          lid_open,
`endif
    output logic [1:0]    motor,
    output logic          busy,
    output logic          done,
    output logic [2:0]    phase,
    output logic [NW-1:0] remain
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CW   = 3'd1,
        S_P1   = 3'd2,
        S_CCW  = 3'd3,
        S_P2   = 3'd4
    } state_t;

    localparam logic [1:0] M_STOP = 2'd0;
    localparam logic [1:0] M_CW   = 2'd1;
    localparam logic [1:0] M_CCW  = 2'd2;

    state_t        state;
    logic [TW-1:0] timer;
    logic [TW-1:0] last_tick;
    logic          lid;
    logic          freeze;
    logic          expire;

`ifdef WASH_LID_INTERLOCK_EN
    assign lid = lid_open;
`else
    assign lid = 1'b0;
`endif

    // An open lid behaves exactly like hold while a run is in progress.
    assign freeze = hold | lid;
    assign expire = (timer == last_tick);
    assign phase  = state;

    // Final timer value of the current phase; timer counts 0..T-1.
    always_comb begin
        last_tick = TW'(PAUSE_T - 1);
        case (state)
            S_CW:    last_tick = TW'(CW_T - 1);
            S_CCW:   last_tick = TW'(CCW_T - 1);
            default: last_tick = TW'(PAUSE_T - 1);
        endcase
    end

    // Sequencer FSM with registered outputs. Priority while busy:
    // abort, then freeze, then phase expiry / timer advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            timer  <= '0;
            remain <= '0;
            motor  <= M_STOP;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                if (start && (cycles != '0) && !lid) begin
                    state  <= S_CW;
                    timer  <= '0;
                    remain <= cycles;
                    motor  <= M_CW;
                    busy   <= 1'b1;
                end
            end else if (abort) begin
                state  <= S_IDLE;
                timer  <= '0;
                remain <= '0;
                motor  <= M_STOP;
                busy   <= 1'b0;
            end else if (freeze) begin
                // State and timer hold their values; only the drum stops.
                motor <= M_STOP;
            end else if (!expire) begin
                timer <= timer + 1'b1;
                // Restores drive after a freeze as well as holding it steady.
                if (state == S_CW) begin
                    motor <= M_CW;
                end else if (state == S_CCW) begin
                    motor <= M_CCW;
                end else begin
                    motor <= M_STOP;
                end
            end else begin
                timer <= '0;
                case (state)
                    S_CW: begin
                        state <= S_P1;
                        motor <= M_STOP;
                    end
                    S_P1: begin
                        state <= S_CCW;
                        motor <= M_CCW;
                    end
                    S_CCW: begin
                        state <= S_P2;
                        motor <= M_STOP;
                    end
                    default: begin
                        if (remain > NW'(1)) begin
                            remain <= remain - 1'b1;
                            state  <= S_CW;
                            motor  <= M_CW;
                        end else begin
                            remain <= '0;
                            state  <= S_IDLE;
                            motor  <= M_STOP;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wash_seq_ctrl.sv
// Bench for wash_seq_ctrl: a fixed vector table, hand-written multi-cycle
// sequences and a randomized run. All results are checked against a model
// that tracks total unheld ticks since start.
module tb_wash_seq_ctrl;

    localparam int TW      = 8;
    localparam int CW_T    = 20;
    localparam int CCW_T   = 20;
    localparam int PAUSE_T = 10;
    localparam int NW      = 4;
    localparam int PERIOD  = CW_T + PAUSE_T + CCW_T + PAUSE_T;
`ifdef WASH_LID_INTERLOCK_EN
    localparam bit LID_EN = 1'b1;
`else
    localparam bit LID_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, start, hold, abort, lid_open;
    logic [NW-1:0] cycles;
    logic [1:0]    motor;
    logic          busy, done;
    logic [2:0]    phase;
    logic [NW-1:0] remain;

    int n_vec = 0;
    int n_err = 0;

    // model state
    bit m_active = 0;
    bit m_held   = 0;
    bit m_done   = 0;
    int m_elapsed = 0;
    int m_n       = 0;

    // clock
    always #5 clk = ~clk;

    wash_seq_ctrl #(
        .TW(TW), .CW_T(CW_T), .CCW_T(CCW_T), .PAUSE_T(PAUSE_T), .NW(NW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .cycles(cycles),
        .hold(hold),
        .abort(abort),
`ifdef WASH_LID_INTERLOCK_EN
        .lid_open(lid_open),
`endif
        .motor(motor),
        .busy(busy),
        .done(done),
        .phase(phase),
        .remain(remain)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Expected outputs from the model: position inside the wash period picks the phase.
    task automatic model_expect(output logic [1:0] em, output logic eb, output logic ed,
                                output logic [2:0] ep, output logic [NW-1:0] er);
        int pos;
        int k;
        em = 2'd0; eb = 1'b0; ep = 3'd0; er = '0;
        ed = m_done;
        if (m_active) begin
            pos = m_elapsed % PERIOD;
            k   = m_elapsed / PERIOD;
            if (pos < CW_T)                          ep = 3'd1;
            else if (pos < CW_T + PAUSE_T)           ep = 3'd2;
            else if (pos < CW_T + PAUSE_T + CCW_T)   ep = 3'd3;
            else                                     ep = 3'd4;
            if (!m_held && ep == 3'd1)      em = 2'd1;
            else if (!m_held && ep == 3'd3) em = 2'd2;
            eb = 1'b1;
            er = NW'(m_n - k);
        end
    endtask

    // Driver: apply one cycle of inputs, advance the model, compare after the edge.
    task automatic tick(input logic r, input logic s, input logic [NW-1:0] c,
                        input logic h, input logic a, input logic l);
        logic [1:0]    em;
        logic          eb, ed;
        logic [2:0]    ep;
        logic [NW-1:0] er;
        bit            lid_eff;
        rst_n = r; start = s; cycles = c; hold = h; abort = a; lid_open = l;
        lid_eff = LID_EN && l;
        m_done = 0;
        if (!r) begin
            m_active = 0; m_elapsed = 0; m_n = 0; m_held = 0;
        end else if (!m_active) begin
            if (s && c != 0 && !lid_eff) begin
                m_active = 1; m_n = int'(c); m_elapsed = 0; m_held = 0;
            end
        end else if (a) begin
            m_active = 0; m_n = 0; m_held = 0;
        end else if (h || lid_eff) begin
            m_held = 1;
        end else begin
            m_held = 0;
            m_elapsed++;
            if (m_elapsed == m_n * PERIOD) begin
                m_active = 0; m_done = 1; m_n = 0;
            end
        end
        @(posedge clk);
        #1;
        model_expect(em, eb, ed, ep, er);
        check("motor", 32'(motor), 32'(em));
        check("busy", 32'(busy), 32'(eb));
        check("done", 32'(done), 32'(ed));
        check("phase", 32'(phase), 32'(ep));
        check("remain", 32'(remain), 32'(er));
    endtask

    task automatic idle_tick();
        tick(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic          rst_n, start;
        logic [NW-1:0] cycles;
        logic          hold, abort;
        logic [1:0]    motor;
        logic          busy, done;
        logic [2:0]    phase;
        logic [NW-1:0] remain;
    } vec_t;

    vec_t vt[9];

    initial begin
        int done_at, dcnt, m1, m2, cw_stop;
        int rem[0:200];

        // rst_n start cyc hold abort | motor busy done phase remain
        vt[0] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 4'd0};
        vt[1] = '{1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 4'd0};
        vt[2] = '{1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 3'd0, 4'd0};
        vt[3] = '{1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 3'd1, 4'd2};
        vt[4] = '{1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 3'd1, 4'd2};
        vt[5] = '{1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 3'd1, 4'd2};
        vt[6] = '{1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 3'd0, 4'd0};
        vt[7] = '{1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 3'd1, 4'd1};
        vt[8] = '{1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 3'd0, 4'd0};

        for (int i = 0; i < 9; i++) begin
            tick(vt[i].rst_n, vt[i].start, vt[i].cycles, vt[i].hold, vt[i].abort, 1'b0);
            check($sformatf("tbl%0d_motor", i), 32'(motor), 32'(vt[i].motor));
            check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(vt[i].busy));
            check($sformatf("tbl%0d_done", i), 32'(done), 32'(vt[i].done));
            check($sformatf("tbl%0d_phase", i), 32'(phase), 32'(vt[i].phase));
            check($sformatf("tbl%0d_remain", i), 32'(remain), 32'(vt[i].remain));
        end

        // single cycle: 20 CW, 10 stop, 20 CCW, 10 stop, done at 60
        tick(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        m1 = (motor == 2'd1) ? 1 : 0; m2 = 0; done_at = -1; dcnt = 0;
        for (int i = 1; i <= 80; i++) begin
            idle_tick();
            if (done) begin dcnt++; if (done_at < 0) done_at = i; end
            if (motor == 2'd1) m1++;
            if (motor == 2'd2) m2++;
        end
        check("one_done_at", 32'(done_at), 32'd60);
        check("one_done_cnt", 32'(dcnt), 32'd1);
        check("one_cw_cycles", 32'(m1), 32'd20);
        check("one_ccw_cycles", 32'(m2), 32'd20);
        check("one_busy_after", 32'(busy), 32'd0);

        // three cycles: remain 3 -> 2 -> 1 -> 0, one done at 180
        tick(1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        rem[0] = int'(remain); done_at = -1; dcnt = 0;
        for (int i = 1; i <= 200; i++) begin
            idle_tick();
            rem[i] = int'(remain);
            if (done) begin dcnt++; if (done_at < 0) done_at = i; end
        end
        check("three_done_at", 32'(done_at), 32'd180);
        check("three_done_cnt", 32'(dcnt), 32'd1);
        check("three_rem0", 32'(rem[0]), 32'd3);
        check("three_rem59", 32'(rem[59]), 32'd3);
        check("three_rem60", 32'(rem[60]), 32'd2);
        check("three_rem120", 32'(rem[120]), 32'd1);
        check("three_rem180", 32'(rem[180]), 32'd0);

        // hold for 7 cycles at CW timer=5: run stretches to 67
        tick(1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        m1 = 1; cw_stop = 0; done_at = -1;
        for (int i = 1; i <= 90; i++) begin
            tick(1'b1, 1'b0, '0, (i >= 6 && i <= 12), 1'b0, 1'b0);
            if (phase == 3'd1 && motor == 2'd0) cw_stop++;
            if (motor == 2'd1) m1++;
            if (done && done_at < 0) done_at = i;
        end
        check("hold_done_at", 32'(done_at), 32'd67);
        check("hold_cw_stopped", 32'(cw_stop), 32'd7);
        check("hold_cw_cycles", 32'(m1), 32'd20);

        // abort at CCW timer=3, then a normal two-cycle run
        tick(1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 33; i++) idle_tick();
        check("abort_pre_phase", 32'(phase), 32'd3);
        tick(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_remain", 32'(remain), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        tick(1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        done_at = -1;
        for (int i = 1; i <= 130; i++) begin
            idle_tick();
            if (done && done_at < 0) done_at = i;
        end
        check("after_abort_done_at", 32'(done_at), 32'd120);

        // reset in the middle of P1
        tick(1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 24; i++) idle_tick();
        check("mid_p1_phase", 32'(phase), 32'd2);
        tick(1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0);
        check("rst_motor", 32'(motor), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_remain", 32'(remain), 32'd0);

`ifdef WASH_LID_INTERLOCK_EN
        // open lid blocks start, then acts as hold during CW
        tick(1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
        check("lid_start_busy", 32'(busy), 32'd0);
        tick(1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        done_at = -1;
        for (int i = 1; i <= 80; i++) begin
            tick(1'b1, 1'b0, '0, 1'b0, 1'b0, (i >= 3 && i <= 6));
            if (i >= 3 && i <= 6) check("lid_motor", 32'(motor), 32'd0);
            if (done && done_at < 0) done_at = i;
        end
        check("lid_done_at", 32'(done_at), 32'd64);
`endif

        // randomized run against the model
        for (int i = 0; i < 4000; i++) begin
            tick(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 7) == 0),
                 NW'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 19) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
